cache_rd_sched: RTL and testbench

Read-channel scheduler between the I-cache/D-cache refill ports and the AXI read bridge. It latches one cache read at a time and arbitrates with D-priority plus a starvation guard for I. It holds the request until the bridge accepts it, then assembles the returned beats into a line. Reads that hit a line still being written back by the D-cache are blocked until that writeback completes. It replaces the combinational fixed-priority read mux in the cache-side AXI path.

---
 rtl/cache_axi_pkg.sv | 34 +++
 rtl/cache_rd_sched_if.sv | 32 +++
 rtl/rd_line_assembler.sv | 50 +++++
 rtl/cache_rd_sched.sv | 159 +++++++++++++++
 tb/tb_cache_rd_sched.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_axi_pkg.sv
// ---------------------------------------------------------------------------
// cache_axi_pkg
// Shared definitions for the cache-side AXI read path:
//   - RD_TYPE_* encodings of the cache read request type field
//   - sched_state_e: states of the read scheduler FSM
//   - line_addr(): clears the byte-within-line offset of an address
// ---------------------------------------------------------------------------
package cache_axi_pkg;

  localparam logic [2:0] RD_TYPE_WORD = 3'b010;
  localparam logic [2:0] RD_TYPE_LINE = 3'b100;

  // Widest address line_addr() handles; callers zero-extend into it.
  localparam int LINE_ADDR_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } sched_state_e;

  // Two addresses fall in the same cache line exactly when their
  // line_addr() values are equal.
  function automatic logic [LINE_ADDR_W-1:0] line_addr(
    input logic [LINE_ADDR_W-1:0] addr,
    input int unsigned            off_bits
  );
    logic [LINE_ADDR_W-1:0] mask;
    mask = (LINE_ADDR_W'(1) << off_bits) - LINE_ADDR_W'(1);
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/cache_rd_sched_if.sv
// ---------------------------------------------------------------------------
// cache_rd_sched_if
// Read channel between the cache read scheduler and the AXI read bridge.
//   rd_req/rd_type/rd_addr : request, held until rd_req && rd_rdy
//   rd_rdy                 : bridge accepts the request
//   ret_valid/ret_last/ret_data : returned beats, last flags the final beat
// master = scheduler side, slave = bridge side.
// ---------------------------------------------------------------------------
interface cache_rd_sched_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              rd_req;
  logic [2:0]        rd_type;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_rdy;
  logic              ret_valid;
  logic              ret_last;
  logic [DATA_W-1:0] ret_data;

  modport master (
    output rd_req, rd_type, rd_addr,
    input  rd_rdy, ret_valid, ret_last, ret_data
  );

  modport slave (
    input  rd_req, rd_type, rd_addr,
    output rd_rdy, ret_valid, ret_last, ret_data
  );

endinterface

// File: rtl/rd_line_assembler.sv
// ---------------------------------------------------------------------------
// rd_line_assembler
// Collects returned read beats into one cache line register.
//   clk, resetn   : clock, asynchronous active-low reset
//   clear_i       : start of a new transaction, zero the line and beat count
//   ret_valid_i   : a beat is present on ret_data_i (already qualified)
//   ret_data_i    : beat data
//   full_i        : 1 = whole-line transfer, 0 = single beat into word0 only
//   line_o        : assembled line, word0 in the LSBs
// ---------------------------------------------------------------------------
module rd_line_assembler #(
  parameter int LINE_WORDS = 4,
  parameter int DATA_W     = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         clear_i,
  input  logic                         ret_valid_i,
  input  logic [DATA_W-1:0]            ret_data_i,
  input  logic                         full_i,
  output logic [LINE_WORDS*DATA_W-1:0] line_o
);

  // One extra bit so the count can sit at LINE_WORDS without wrapping
  // back onto word0.
  localparam int CW = $clog2(LINE_WORDS) + 1;

  logic [CW-1:0]                       beat_cnt_q;
  logic [LINE_WORDS-1:0][DATA_W-1:0]   line_q;
  logic [CW-1:0]                       limit;

  assign limit  = full_i ? CW'(LINE_WORDS) : CW'(1);
  assign line_o = line_q;

  // Beats past the limit are dropped and the count saturates, so a
  // misbehaving bridge cannot corrupt words already captured.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat_cnt_q <= '0;
      line_q     <= '0;
    end else if (clear_i) begin
      beat_cnt_q <= '0;
      line_q     <= '0;
    end else if (ret_valid_i && (beat_cnt_q < limit)) begin
      line_q[beat_cnt_q[CW-2:0]] <= ret_data_i;
      beat_cnt_q                 <= beat_cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/cache_rd_sched.sv
// ---------------------------------------------------------------------------
// cache_rd_sched
// Serialises I-cache and D-cache refill reads onto one AXI read bridge.
// D has priority, but after STARVE_MAX consecutive D grants with I waiting
// the next grant goes to I. A read to a line the D-cache is still writing
// back waits in IDLE until the writeback completes.
//   clk, resetn                         : clock, asynchronous active-low reset
//   i_rd_req_i/type/addr, i_rd_finish_o : I-cache read port
//   d_rd_req_i/type/addr, d_rd_finish_o : D-cache read port
//   rd_data_o                           : assembled line, word0 in the LSBs
//   wb_pending_i, wb_addr_i             : D writeback in flight and its address
//   busy_o                              : scheduler not idle
//   rd_bus                              : request/return channel to the bridge
// ---------------------------------------------------------------------------
module cache_rd_sched
  import cache_axi_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         i_rd_req_i,
  input  logic [2:0]                   i_rd_type_i,
  input  logic [ADDR_W-1:0]            i_rd_addr_i,
  output logic                         i_rd_finish_o,
  input  logic                         d_rd_req_i,
  input  logic [2:0]                   d_rd_type_i,
  input  logic [ADDR_W-1:0]            d_rd_addr_i,
  output logic                         d_rd_finish_o,
  output logic [LINE_WORDS*DATA_W-1:0] rd_data_o,
  input  logic                         wb_pending_i,
  input  logic [ADDR_W-1:0]            wb_addr_i,
  output logic                         busy_o,
  cache_rd_sched_if.master             rd_bus
);

  localparam int unsigned OFF_BITS   = $clog2(LINE_WORDS * DATA_W / 8);
  localparam int          SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  sched_state_e      state_q, state_d;
  logic              owner_i_q, owner_i_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        type_q, type_d;
  logic              rd_req_q, rd_req_d;
  logic [SW-1:0]     starve_q, starve_d;

  logic i_blocked, d_blocked;
  logic i_elig, d_elig;
  logic grant_i, grant_d;

  // A side is held back while its line is the one being written back.
  assign i_blocked = wb_pending_i &&
                     (line_addr(LINE_ADDR_W'(i_rd_addr_i), OFF_BITS) ==
                      line_addr(LINE_ADDR_W'(wb_addr_i), OFF_BITS));
  assign d_blocked = wb_pending_i &&
                     (line_addr(LINE_ADDR_W'(d_rd_addr_i), OFF_BITS) ==
                      line_addr(LINE_ADDR_W'(wb_addr_i), OFF_BITS));
  assign i_elig = i_rd_req_i && !i_blocked;
  assign d_elig = d_rd_req_i && !d_blocked;

  // State and latched-request registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      owner_i_q <= 1'b0;
      addr_q    <= '0;
      type_q    <= '0;
      rd_req_q  <= 1'b0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_i_q <= owner_i_d;
      addr_q    <= addr_d;
      type_q    <= type_d;
      rd_req_q  <= rd_req_d;
      starve_q  <= starve_d;
    end
  end

  // Arbitration in IDLE and the request/data/done sequence.
  always_comb begin
    state_d   = state_q;
    owner_i_d = owner_i_q;
    addr_d    = addr_q;
    type_d    = type_q;
    rd_req_d  = rd_req_q;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (d_elig && (!i_elig || (starve_q < STARVE_LIM))) begin
          grant_d = 1'b1;
        end else if (i_elig) begin
          grant_i = 1'b1;
        end
        if (grant_i || grant_d) begin
          state_d   = ST_REQ;
          rd_req_d  = 1'b1;
          owner_i_d = grant_i;
          addr_d    = grant_i ? i_rd_addr_i : d_rd_addr_i;
          type_d    = grant_i ? i_rd_type_i : d_rd_type_i;
        end
      end
      ST_REQ: begin
        if (rd_req_q && rd_bus.rd_rdy) begin
          state_d  = ST_DATA;
          rd_req_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (rd_bus.ret_valid && rd_bus.ret_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Starvation guard: counts D grants that jumped ahead of a waiting I.
  always_comb begin
    starve_d = starve_q;
    if (!i_rd_req_i || grant_i) begin
      starve_d = '0;
    end else if (grant_d && (starve_q < STARVE_LIM)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  rd_line_assembler #(
    .LINE_WORDS (LINE_WORDS),
    .DATA_W     (DATA_W)
  ) u_asm (
    .clk         (clk),
    .resetn      (resetn),
    .clear_i     (grant_i || grant_d),
    .ret_valid_i ((state_q == ST_DATA) && rd_bus.ret_valid),
    .ret_data_i  (rd_bus.ret_data),
    .full_i      (type_q == RD_TYPE_LINE),
    .line_o      (rd_data_o)
  );

  assign rd_bus.rd_req  = rd_req_q;
  assign rd_bus.rd_type = type_q;
  assign rd_bus.rd_addr = addr_q;

  assign i_rd_finish_o = (state_q == ST_DONE) && owner_i_q;
  assign d_rd_finish_o = (state_q == ST_DONE) && !owner_i_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cache_rd_sched.sv
// ---------------------------------------------------------------------------
// tb_cache_rd_sched
// Directed bench for cache_rd_sched (LINE_WORDS=4, DATA_W=32, STARVE_MAX=3).
// Inputs change just after the falling edge and outputs are sampled at the
// falling edge, half a cycle away from the rising edge the design uses.
// ---------------------------------------------------------------------------
module tb_cache_rd_sched;
  import cache_axi_pkg::*;

  localparam int LW = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              i_req = 1'b0;
  logic [2:0]        i_type = 3'b000;
  logic [AW-1:0]     i_addr = '0;
  logic              i_fin;
  logic              d_req = 1'b0;
  logic [2:0]        d_type = 3'b000;
  logic [AW-1:0]     d_addr = '0;
  logic              d_fin;
  logic [LW*DW-1:0]  rd_data;
  logic              wb_pending = 1'b0;
  logic [AW-1:0]     wb_addr = '0;
  logic              busy;

  int total = 0;
  int bad   = 0;

  cache_rd_sched_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  cache_rd_sched #(
    .LINE_WORDS (LW),
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .STARVE_MAX (3)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .i_rd_req_i    (i_req),
    .i_rd_type_i   (i_type),
    .i_rd_addr_i   (i_addr),
    .i_rd_finish_o (i_fin),
    .d_rd_req_i    (d_req),
    .d_rd_type_i   (d_type),
    .d_rd_addr_i   (d_addr),
    .d_rd_finish_o (d_fin),
    .rd_data_o     (rd_data),
    .wb_pending_i  (wb_pending),
    .wb_addr_i     (wb_addr),
    .busy_o        (busy),
    .rd_bus        (bus)
  );

  always #5 clk = ~clk;

  // Safety net in case the design never lets the sequence move on.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents one return beat for one cycle.
  task automatic applyStimulus(input logic v, input logic l, input logic [31:0] d);
    bus.ret_valid = v;
    bus.ret_last  = l;
    bus.ret_data  = d;
    nextCycle();
    bus.ret_valid = 1'b0;
    bus.ret_last  = 1'b0;
  endtask

  // Waits (bounded) for a request, accepts it, returns nbeats beats
  // seed, seed+1, ... with last on the final one, and stops in DONE.
  task automatic doBurst(input int nbeats, input logic [31:0] seed,
                         output logic [31:0] addrSeen, output logic [1:0] fin);
    int waitCnt = 0;
    while ((bus.rd_req !== 1'b1) && (waitCnt < 20)) begin
      nextCycle();
      waitCnt++;
    end
    checkOutput("req_seen", 128'(bus.rd_req), 128'(1));
    addrSeen   = bus.rd_addr;
    bus.rd_rdy = 1'b1;
    nextCycle();
    for (int b = 0; b < nbeats; b++) begin
      applyStimulus(1'b1, (b == nbeats - 1), seed + 32'(b));
    end
    fin = {i_fin, d_fin};
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  f;
    logic [7:0]  grantI;

    bus.rd_rdy    = 1'b0;
    bus.ret_valid = 1'b0;
    bus.ret_last  = 1'b0;
    bus.ret_data  = '0;

    // Reset state.
    #2;
    checkOutput("rst_data", 128'(rd_data), 128'(0));
    checkOutput("rst_ctl", 128'({busy, bus.rd_req, i_fin, d_fin}), 128'(0));
    checkOutput("rst_req", 128'({bus.rd_type, bus.rd_addr}), 128'(0));
    nextCycle();
    resetn = 1'b1;

    // D-only line read.
    d_req      = 1'b1;
    d_type     = RD_TYPE_LINE;
    d_addr     = 32'h1000_0040;
    bus.rd_rdy = 1'b1;
    nextCycle();
    checkOutput("t1_req", 128'({busy, bus.rd_req, bus.rd_type, bus.rd_addr}),
                128'({1'b1, 1'b1, 3'b100, 32'h1000_0040}));
    nextCycle();
    checkOutput("t1_req_drop", 128'(bus.rd_req), 128'(0));
    applyStimulus(1'b1, 1'b0, 32'h11);
    applyStimulus(1'b1, 1'b0, 32'h22);
    applyStimulus(1'b1, 1'b0, 32'h33);
    applyStimulus(1'b1, 1'b1, 32'h44);
    checkOutput("t1_fin", 128'({i_fin, d_fin}), 128'(2'b01));
    checkOutput("t1_data", 128'(rd_data), 128'h00000044_00000033_00000022_00000011);
    d_req = 1'b0;
    nextCycle();
    checkOutput("t1_idle", 128'({busy, i_fin, d_fin}), 128'(0));
    checkOutput("t1_hold", 128'(rd_data), 128'h00000044_00000033_00000022_00000011);

    // Both sides held: D,D,D,I,D,D,D,I.
    grantI = 8'b1000_1000;
    i_req  = 1'b1;
    i_type = RD_TYPE_WORD;
    i_addr = 32'h0000_2000;
    d_req  = 1'b1;
    d_type = RD_TYPE_WORD;
    d_addr = 32'h0000_3000;
    for (int k = 0; k < 8; k++) begin
      doBurst(1, 32'(k), a, f);
      checkOutput($sformatf("t2_grant%0d", k), 128'(a),
                  grantI[k] ? 128'(32'h0000_2000) : 128'(32'h0000_3000));
      checkOutput($sformatf("t2_fin%0d", k), 128'(f),
                  grantI[k] ? 128'(2'b10) : 128'(2'b01));
    end
    i_req = 1'b0;
    d_req = 1'b0;
    nextCycle();
    checkOutput("t2_fin_once", 128'({busy, i_fin, d_fin}), 128'(0));

    // Writeback hazard blocks D, I goes first.
    wb_pending = 1'b1;
    wb_addr    = 32'h2000_0010;
    d_addr     = 32'h2000_001C;
    i_addr     = 32'h3000_0000;
    i_req      = 1'b1;
    d_req      = 1'b1;
    doBurst(1, 32'hA5, a, f);
    checkOutput("t3_first", 128'(a), 128'(32'h3000_0000));
    checkOutput("t3_fin_i", 128'(f), 128'(2'b10));
    i_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      checkOutput($sformatf("t3_blocked%0d", k), 128'({busy, bus.rd_req}), 128'(0));
    end
    wb_pending = 1'b0;
    nextCycle();
    checkOutput("t3_d_after_wb", 128'({bus.rd_req, bus.rd_addr}),
                128'({1'b1, 32'h2000_001C}));
    doBurst(1, 32'h5A, a, f);
    checkOutput("t3_fin_d", 128'(f), 128'(2'b01));
    d_req = 1'b0;
    nextCycle();

    // Bridge stalls 5 cycles; stray beats in REQ and excess beats ignored.
    bus.rd_rdy    = 1'b0;
    d_req         = 1'b1;
    d_type        = RD_TYPE_LINE;
    d_addr        = 32'h4000_0080;
    bus.ret_valid = 1'b1;
    bus.ret_last  = 1'b1;
    bus.ret_data  = 32'h55;
    for (int k = 0; k < 5; k++) begin
      nextCycle();
      checkOutput($sformatf("t4_hold%0d", k), 128'({bus.rd_req, bus.rd_type, bus.rd_addr}),
                  128'({1'b1, 3'b100, 32'h4000_0080}));
    end
    bus.ret_valid = 1'b0;
    bus.ret_last  = 1'b0;
    bus.rd_rdy    = 1'b1;
    nextCycle();
    checkOutput("t4_req_drop", 128'({busy, bus.rd_req}), 128'(2'b10));
    applyStimulus(1'b1, 1'b0, 32'hA0A0_0000);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'hA1A1_1111);
    applyStimulus(1'b1, 1'b0, 32'hA2A2_2222);
    applyStimulus(1'b1, 1'b0, 32'hA3A3_3333);
    applyStimulus(1'b1, 1'b0, 32'hBAD0_BAD0);
    applyStimulus(1'b1, 1'b1, 32'hBAD1_BAD1);
    checkOutput("t4_fin", 128'({i_fin, d_fin}), 128'(2'b01));
    checkOutput("t4_data", 128'(rd_data), 128'hA3A3_3333_A2A2_2222_A1A1_1111_A0A0_0000);
    d_req = 1'b0;
    nextCycle();

    // Single-beat read fills word0 only.
    d_type = RD_TYPE_WORD;
    d_addr = 32'h5000_0004;
    d_req  = 1'b1;
    doBurst(1, 32'hDEAD_BEEF, a, f);
    checkOutput("t5_fin", 128'(f), 128'(2'b01));
    checkOutput("t5_data", 128'(rd_data), 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
    d_req = 1'b0;
    nextCycle();

    // Reset during beat 2.
    d_type = RD_TYPE_LINE;
    d_addr = 32'h6000_0000;
    d_req  = 1'b1;
    nextCycle();
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h61);
    bus.ret_valid = 1'b1;
    bus.ret_data  = 32'h62;
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("t6_rst_data", 128'(rd_data), 128'(0));
    checkOutput("t6_rst_ctl", 128'({busy, bus.rd_req, i_fin, d_fin}), 128'(0));
    checkOutput("t6_rst_req", 128'({bus.rd_type, bus.rd_addr}), 128'(0));
    nextCycle();
    resetn        = 1'b1;
    d_req         = 1'b0;
    bus.ret_valid = 1'b1;
    bus.ret_last  = 1'b1;
    bus.ret_data  = 32'h99;
    nextCycle();
    checkOutput("t6_stray", 128'({busy, i_fin, d_fin}), 128'(0));
    checkOutput("t6_stray_data", 128'(rd_data), 128'(0));
    bus.ret_valid = 1'b0;
    bus.ret_last  = 1'b0;
    d_addr        = 32'h6000_0040;
    d_req         = 1'b1;
    doBurst(4, 32'h70, a, f);
    checkOutput("t6_addr", 128'(a), 128'(32'h6000_0040));
    checkOutput("t6_fin", 128'(f), 128'(2'b01));
    checkOutput("t6_data", 128'(rd_data), 128'h00000073_00000072_00000071_00000070);
    d_req = 1'b0;
    nextCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
